// File: rtl/fp_addsub_param.sv
// Multi-cycle IEEE 754 adder/subtractor with parametrised exponent/fraction widths and RNE rounding.
// Define FP_ADDSUB_SUBNORMAL_EN to keep subnormals; by default they are flushed to signed zero.
module fp_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] data_a,
  input  logic [EXP_W+MAN_W:0] data_b,
  output logic [EXP_W+MAN_W:0] data_o,
  output logic                 busy,
  output logic                 ready,
  output logic [3:0]           flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [XW-1:0]    EXP_SAT  = {2'b00, EXP_ONES};
  localparam logic [XW-1:0]    BIG_DIFF = XW'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ADD    = 3'd3,
    S_NORM   = 3'd4,
    S_ROUND  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t state, state_n;

  logic [W-1:0]  a_q, b_q;
  logic          op_q;
  logic          sign_r, sub_r;
  logic [XW-1:0] exp_r, diff_r;
  logic [SW-1:0] sig_a, sig_b;

  function automatic logic [MAN_W+1:0] round_rne(input logic [SW-1:0] s);
    logic up;
    up = s[2] & (s[1] | s[0] | s[3]);
    return {1'b0, s[SW-1:3]} + {{(MAN_W+1){1'b0}}, up};
  endfunction

  function automatic logic [W-1:0] inf_word(input logic s);
    return {s, EXP_ONES, {MAN_W{1'b0}}};
  endfunction

  logic             sa, sb, a_nan, b_nan, a_snan, b_snan;
  logic             a_inf, b_inf, a_zero, b_zero, a_ge, special;
  logic [EXP_W-1:0] ea_f, eb_f;
  logic [MAN_W-1:0] fa, fb;
  logic [XW-1:0]    ea, eb, diff_u;
  logic [SW-1:0]    ma, mb;
  logic [W-1:0]     spec_word;
  logic [3:0]       spec_flags;

  always_comb begin
    spec_word  = '0;
    spec_flags = '0;
    sa   = a_q[W-1];
    sb   = b_q[W-1] ^ ~op_q;
    ea_f = a_q[W-2:MAN_W];
    eb_f = b_q[W-2:MAN_W];
    fa   = a_q[MAN_W-1:0];
    fb   = b_q[MAN_W-1:0];
    a_nan  = (ea_f == EXP_ONES) && (fa != '0);
    b_nan  = (eb_f == EXP_ONES) && (fb != '0);
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];
    a_inf  = (ea_f == EXP_ONES) && (fa == '0);
    b_inf  = (eb_f == EXP_ONES) && (fb == '0);
`ifdef FP_ADDSUB_SUBNORMAL_EN
    a_zero = (ea_f == '0) && (fa == '0);
    b_zero = (eb_f == '0) && (fb == '0);
    ea = (ea_f == '0) ? XW'(1) : {2'b00, ea_f};
    eb = (eb_f == '0) ? XW'(1) : {2'b00, eb_f};
    ma = {(ea_f != '0), fa, 3'b000};
    mb = {(eb_f != '0), fb, 3'b000};
`else
    a_zero = (ea_f == '0);
    b_zero = (eb_f == '0);
    ea = {2'b00, ea_f};
    eb = {2'b00, eb_f};
    ma = a_zero ? '0 : {1'b1, fa, 3'b000};
    mb = b_zero ? '0 : {1'b1, fb, 3'b000};
`endif
    a_ge    = (ea > eb) || ((ea == eb) && (ma >= mb));
    diff_u  = a_ge ? (ea - eb) : (eb - ea);
    special = a_nan | b_nan | a_inf | b_inf | (a_zero & b_zero);
    if (a_nan || b_nan) begin
      spec_word  = QNAN;
      spec_flags = {a_snan | b_snan, 3'b000};
    end else if (a_inf && b_inf && (sa != sb)) begin
      spec_word  = QNAN;
      spec_flags = 4'b1000;
    end else if (a_inf) begin
      spec_word = inf_word(sa);
    end else if (b_inf) begin
      spec_word = inf_word(sb);
    end else begin
      spec_word = {sa & sb, {(W-1){1'b0}}};
    end
  end

  logic [SW:0]      sum;
  logic             norm_shift, inexact, tiny;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W:0]   man_n;
  logic [XW-1:0]    exp_n;
  logic [W-1:0]     rnd_word;
  logic [3:0]       rnd_flags;

  always_comb begin
    sum = sub_r ? ({1'b0, sig_a} - {1'b0, sig_b}) : ({1'b0, sig_a} + {1'b0, sig_b});
    norm_shift = !sig_a[SW-1] && (exp_r > XW'(1));
    rnd   = round_rne(sig_a);
    man_n = rnd[MAN_W:0];
    exp_n = exp_r;
    if (rnd[MAN_W+1]) begin
      man_n = rnd[MAN_W+1:1];
      exp_n = exp_r + XW'(1);
    end
    inexact   = |sig_a[2:0];
    rnd_word  = '0;
    rnd_flags = '0;
`ifdef FP_ADDSUB_SUBNORMAL_EN
    tiny = !sig_a[SW-1];
    if (exp_n >= EXP_SAT) begin
      rnd_word  = inf_word(sign_r);
      rnd_flags = 4'b0101;
    end else begin
      // A round-up carry into the hidden bit lifts a subnormal to exponent field 1.
      rnd_word  = {sign_r, (man_n[MAN_W] ? exp_n[EXP_W-1:0] : {EXP_W{1'b0}}), man_n[MAN_W-1:0]};
      rnd_flags = {2'b00, tiny & inexact, inexact};
    end
`else
    tiny = !man_n[MAN_W];
    if (exp_n >= EXP_SAT) begin
      rnd_word  = inf_word(sign_r);
      rnd_flags = 4'b0101;
    end else if (tiny) begin
      rnd_word  = {sign_r, {(W-1){1'b0}}};
      rnd_flags = 4'b0011;
    end else begin
      rnd_word  = {sign_r, exp_n[EXP_W-1:0], man_n[MAN_W-1:0]};
      rnd_flags = {3'b000, inexact};
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_UNPACK;
      S_UNPACK: begin
        if (special)             state_n = S_DONE;
        else if (diff_u == '0)   state_n = S_ADD;
        else                     state_n = S_ALIGN;
      end
      S_ALIGN:  if ((diff_r <= XW'(1)) || (diff_r > BIG_DIFF)) state_n = S_ADD;
      S_ADD:    state_n = (sum == '0) ? S_DONE : S_NORM;
      S_NORM:   if (!norm_shift) state_n = S_ROUND;
      S_ROUND:  state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign ready = (state == S_DONE);

  always_ff @(posedge clock) begin
    case (state)
      S_IDLE: begin
        if (start) begin
          a_q  <= data_a;
          b_q  <= data_b;
          op_q <= op;
        end
      end
      // UNPACK: larger magnitude always lands in sig_a
      S_UNPACK: begin
        sign_r <= a_ge ? sa : sb;
        sub_r  <= sa ^ sb;
        exp_r  <= a_ge ? ea : eb;
        sig_a  <= a_ge ? ma : mb;
        sig_b  <= a_ge ? mb : ma;
        diff_r <= diff_u;
      end
      // ALIGN: bit 0 is sticky, so it absorbs everything shifted past it
      S_ALIGN: begin
        if (diff_r > BIG_DIFF) begin
          sig_b  <= {{(SW-1){1'b0}}, |sig_b};
          diff_r <= '0;
        end else begin
          sig_b  <= {1'b0, sig_b[SW-1:2], sig_b[1] | sig_b[0]};
          diff_r <= diff_r - XW'(1);
        end
      end
      S_ADD: begin
        if (sum[SW]) begin
          sig_a <= {sum[SW:2], sum[1] | sum[0]};
          exp_r <= exp_r + XW'(1);
        end else begin
          sig_a <= sum[SW-1:0];
        end
      end
      S_NORM: begin
        if (norm_shift) begin
          sig_a <= {sig_a[SW-2:0], 1'b0};
          exp_r <= exp_r - XW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_o <= '0;
      flags  <= '0;
    end else if ((state == S_UNPACK) && special) begin
      data_o <= spec_word;
      flags  <= spec_flags;
    end else if ((state == S_ADD) && (sum == '0)) begin
      data_o <= '0;
      flags  <= '0;
    end else if (state == S_ROUND) begin
      data_o <= rnd_word;
      flags  <= rnd_flags;
    end
  end

endmodule

// File: tb/tb_fp_addsub_param.sv
// Directed bench for fp_addsub_param: single-precision and half-precision instances.
module tb_fp_addsub_param;

  logic        clock;
  logic        sp_reset, sp_start, sp_op, sp_busy, sp_ready;
  logic [31:0] sp_a, sp_b, sp_data;
  logic [3:0]  sp_flags;
  logic        hp_reset, hp_start, hp_op, hp_busy, hp_ready;
  logic [15:0] hp_a, hp_b, hp_data;
  logic [3:0]  hp_flags;
  int          n_vec;
  int          n_bad;
  int          rdy_seen;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  fp_addsub_param u_sp (
    .clock(clock), .reset(sp_reset), .start(sp_start), .op(sp_op),
    .data_a(sp_a), .data_b(sp_b), .data_o(sp_data),
    .busy(sp_busy), .ready(sp_ready), .flags(sp_flags)
  );

  fp_addsub_param #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clock(clock), .reset(hp_reset), .start(hp_start), .op(hp_op),
    .data_a(hp_a), .data_b(hp_b), .data_o(hp_data),
    .busy(hp_busy), .ready(hp_ready), .flags(hp_flags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input bit hp, input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input logic [31:0] exp_d, input logic [3:0] exp_f,
                        input int exp_lat);
    int   lat;
    logic rdy;
    @(negedge clock);
    if (hp) begin
      hp_a = a[15:0]; hp_b = b[15:0]; hp_op = o; hp_start = 1'b1;
    end else begin
      sp_a = a; sp_b = b; sp_op = o; sp_start = 1'b1;
    end
    @(posedge clock); #1;
    hp_start = 1'b0;
    sp_start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      rdy = hp ? hp_ready : sp_ready;
      if (rdy) begin
        lat = i;
        break;
      end
      @(posedge clock); #1;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " data"}, hp ? 64'(hp_data) : 64'(sp_data), 64'(exp_d));
    check({tag, " flags"}, hp ? 64'(hp_flags) : 64'(sp_flags), 64'(exp_f));
    check({tag, " busy at done"}, hp ? 64'(hp_busy) : 64'(sp_busy), 64'd1);
    @(posedge clock); #1;
    check({tag, " idle after"}, hp ? 64'({hp_busy, hp_ready}) : 64'({sp_busy, sp_ready}), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    sp_reset = 1'b1; sp_start = 1'b0; sp_op = 1'b0; sp_a = '0; sp_b = '0;
    hp_reset = 1'b1; hp_start = 1'b0; hp_op = 1'b0; hp_a = '0; hp_b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("sp reset data", 64'(sp_data), 64'd0);
    check("sp reset flags", 64'(sp_flags), 64'd0);
    check("sp reset busy/ready", 64'({sp_busy, sp_ready}), 64'd0);
    check("hp reset data", 64'(hp_data), 64'd0);
    @(negedge clock);
    sp_reset = 1'b0;
    hp_reset = 1'b0;

    run_op(1'b0, "1+2",        32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, 4'b0000, 6);
    run_op(1'b0, "1-1",        32'h3F800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000, 3);
    run_op(1'b0, "tie even",   32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, 4'b0001, 29);
    run_op(1'b0, "round up",   32'h3F800000, 32'h34400000, 1'b1, 32'h3F800002, 4'b0001, 28);
    run_op(1'b0, "overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 4'b0101, 5);
    run_op(1'b0, "inf-inf",    32'h7F800000, 32'h7F800000, 1'b0, 32'h7FC00000, 4'b1000, 2);
    run_op(1'b0, "snan",       32'h7F800001, 32'h3F800000, 1'b1, 32'h7FC00000, 4'b1000, 2);
    run_op(1'b0, "qnan",       32'h7FC00000, 32'h3F800000, 1'b1, 32'h7FC00000, 4'b0000, 2);
    run_op(1'b0, "-inf+1",     32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 4'b0000, 2);
    run_op(1'b0, "-0 minus +0", 32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 4'b0000, 2);
    run_op(1'b0, "-0 plus +0", 32'h80000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 2);
    run_op(1'b0, "2-1.5 norm", 32'h40000000, 32'h3FC00000, 1'b0, 32'h3F000000, 4'b0000, 8);
    run_op(1'b0, "1-2 neg",    32'h3F800000, 32'h40000000, 1'b0, 32'hBF800000, 4'b0000, 7);
    run_op(1'b0, "far sticky", 32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 4'b0001, 6);
`ifdef FP_ADDSUB_SUBNORMAL_EN
    run_op(1'b0, "subnormal",  32'h00800000, 32'h00400000, 1'b0, 32'h00400000, 4'b0000, 5);
`else
    run_op(1'b0, "subnormal",  32'h00800000, 32'h00400000, 1'b0, 32'h00800000, 4'b0000, 6);
`endif

    // start held high through an in-flight operation, with new operands on the bus
    @(negedge clock);
    sp_a = 32'h7F800000; sp_b = 32'h7F800000; sp_op = 1'b0; sp_start = 1'b1;
    @(posedge clock); #1;
    sp_a = 32'h3F800000; sp_b = 32'h40000000; sp_op = 1'b1;
    check("held start busy", 64'(sp_busy), 64'd1);
    @(posedge clock); #1;
    check("held start ready", 64'(sp_ready), 64'd1);
    check("held start data", 64'(sp_data), 64'h7FC00000);
    check("held start flags", 64'(sp_flags), 64'h8);
    sp_start = 1'b0;
    @(posedge clock); #1;
    check("held start idle", 64'({sp_busy, sp_ready}), 64'd0);

    run_op(1'b1, "hp 1+1", 32'h00003C00, 32'h00003C00, 1'b1, 32'h00004000, 4'b0000, 5);

    // reset while the half-precision unit is aligning
    @(negedge clock);
    hp_a = 16'h3C00; hp_b = 16'h2C00; hp_op = 1'b1; hp_start = 1'b1;
    @(posedge clock); #1;
    hp_start = 1'b0;
    @(posedge clock); #1;
    check("hp mid-align busy", 64'(hp_busy), 64'd1);
    hp_reset = 1'b1;
    @(posedge clock); #1;
    check("hp reset busy", 64'(hp_busy), 64'd0);
    check("hp reset ready", 64'(hp_ready), 64'd0);
    check("hp reset data", 64'(hp_data), 64'd0);
    check("hp reset flags", 64'(hp_flags), 64'd0);
    hp_reset = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (hp_ready) rdy_seen++;
    end
    check("hp no ready after reset", 64'(rdy_seen), 64'd0);
    run_op(1'b1, "hp 1+1/16", 32'h00003C00, 32'h00002C00, 1'b1, 32'h00003C40, 4'b0000, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_addsub_param.md
# fp_addsub_param

Parametrised, multi-cycle IEEE 754 floating-point adder/subtractor, the next generation of the single-precision `soma` unit. Exponent and mantissa widths are parameters, so one RTL source covers half, single and double precision. The block adds round-to-nearest-even with guard/round/sticky bits, full special-value handling and exception flags. It sits behind the same start/busy/ready handshake used by the existing arithmetic units and is driven by the datapath sequencer.

## Interface
- `EXP_W`, default 8: exponent field width, range 4..11.
- `MAN_W`, default 23: stored fraction width, range 3..52. The word width `W = 1 + EXP_W + MAN_W`.
- `clock` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `start` input, 1 bit: request; sampled only in IDLE.
- `op` input, 1 bit: 1 = add (a+b), 0 = subtract (a−b); sampled with `start`.
- `data_a`, `data_b` input, W bits: operands; sampled with `start`.
- `data_o` output, W bits: result; valid when `ready`=1 and held until the next accepted `start`.
- `busy` output, 1 bit: high while an operation is in flight.
- `ready` output, 1 bit: one-cycle completion pulse.
- `flags` output, 4 bits: {invalid, overflow, underflow, inexact}; updated with `ready` and held with `data_o`.

## Operation
- FSM states: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → DONE → IDLE.
- **IDLE**: if `start`=1, register `data_a`, `data_b` and `op`, then go to UNPACK. `start` is ignored in every other state.
- **UNPACK**: split the operands into sign, exponent and significand, with hidden bit 1 for normal operands. Effective sign of b = `b.sign ^ ~op`. Swap the operands so that |a| ≥ |b|, comparing by exponent and then significand.
- **UNPACK special cases** go directly to DONE:
  - Any NaN operand → canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0). `invalid` is set only for signalling NaN inputs.
  - ∞ + (−∞) effective → canonical qNaN, `invalid`=1.
  - ∞ with a finite operand → that ∞.
  - Both operands zero → +0, except −0 when both effective signs are negative.
- **ALIGN**: shift the smaller significand right by 1 per cycle until the exponent difference is 0. Bits shifted out OR into sticky. A difference > `MAN_W+3` is handled in one cycle: the significand is cleared and sticky is set to the OR of all of its bits.
- **ADD**: add or subtract the `MAN_W+4`-bit extended significands (hidden bit + fraction + G, R, S). On carry-out, shift right 1 in the same cycle, increment the exponent and fold the lost bit into sticky. An exact zero result gives +0 and goes directly to DONE.
- **NORM**: shift left 1 per cycle while the hidden bit is 0 and exponent > 1, decrementing the exponent each cycle.
- **ROUND**: round to nearest, ties to even, using G, R and S.
  - Round-up carry renormalises the result in the same cycle.
  - `inexact` = G|R|S.
  - Exponent ≥ all-ones → ±∞, with `overflow`=1 and `inexact`=1.
- **DONE**: drive `data_o` and `flags`, pulse `ready` for this cycle only, then return to IDLE.
- **Reset**, from any state including mid-operation: the next edge forces IDLE and sets `data_o`=0, `flags`=0, `busy`=0, `ready`=0. The in-flight operation is discarded.

## Timing
- Reset values: `data_o`=0, `flags`=0, `busy`=0, `ready`=0.
- `busy` goes high the cycle after `start` is accepted and stays high through the DONE cycle. It is low when `ready` is low and the FSM is in IDLE.
- Normal path latency, measured from the `start` edge to the `ready` cycle: 5 + `n_align` + `n_norm` cycles.
  - `n_align` = min(exponent difference, 1 if the difference > `MAN_W+3`).
  - `n_norm` ≤ `MAN_W+1`.
- Special-case and exact-zero paths complete in 2 cycles (UNPACK then DONE) or 3 cycles (via ADD).
- Back-to-back operation: `start` asserted in the cycle after `ready` is accepted, because the FSM is then in IDLE.

## Configuration
- Macro: `FP_ADDSUB_SUBNORMAL_EN`.
- Defined: subnormal inputs are used with hidden bit 0 and effective exponent 1. Results below the normal range are denormalised: NORM stops at exponent 1 and the result is encoded with exponent field 0. `underflow` = tiny and inexact.
- Undefined: subnormal inputs are flushed to zero of the same sign in UNPACK. Tiny results are flushed to signed zero with `underflow`=1 and `inexact`=1.

## Test plan
- Single precision: 0x3F800000 + 0x40000000 (op=1) → `data_o`=0x40400000, `flags`=0, `ready` on cycle 6 after `start`.
- 0x3F800000 − 0x3F800000 → 0x00000000, `flags`=0. Tie case: 0x3F800000 + 0x33800000 → 0x3F800000, `inexact`=1.
- 0x3F800000 + 0x34400000 → 0x3F800002, `inexact`=1. Also 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, `overflow`=1, `inexact`=1.
- 0x7F800000 − 0x7F800000 → 0x7FC00000, `invalid`=1, `ready` 2 cycles after `start`. Also `start` held high while `busy`=1 is ignored.
- Subnormal: 0x00800000 − 0x00400000 → 0x00400000 with the macro defined, 0x00800000 without it.
- `EXP_W`=5, `MAN_W`=10: 0x3C00 + 0x3C00 → 0x4000. Assert `reset` mid-ALIGN → next cycle `busy`=0, `data_o`=0, and no `ready` pulse occurs.
